// File: rtl/pwm_ramp_if.sv
// Command / status bundle between a ramp source and pwm_ramp_ctrl.
// Handshake: a command transfers on a clk edge where cmd_valid & cmd_ready; the source holds cmd_* stable until then.
interface pwm_ramp_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic [WIDTH-1:0] cmd_step;
    logic [DIV_W-1:0] cmd_div;
    logic             abort;
    logic             sync_in;
    logic [WIDTH-1:0] duty_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_div, abort, sync_in,
        input  cmd_ready, duty_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_div, abort, sync_in,
        output cmd_ready, duty_out, busy, done
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: walks duty_out toward a commanded target by a fixed step,
// one step every cmd_div PWM periods, counted on rising edges of the core's sync.
module pwm_ramp_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int DIV_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    pwm_ramp_if.slave    bus,
    output logic         o_dbg_state
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_duty, w_duty_nxt;
    logic [WIDTH-1:0]   r_tgt, w_tgt_nxt;
    logic [WIDTH-1:0]   r_step, w_step_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [DIV_W-1:0]   r_pcnt, w_pcnt_nxt;
    logic               r_done, w_done_nxt;
    logic               r_sync_q;

    logic [WIDTH-1:0]   w_tgt_clamp;
    logic [WIDTH-1:0]   w_step_eff;
    logic               w_accept;
    logic               w_jump;
    logic               w_sync_rise;
    logic               w_period_end;
    logic               w_up;
    logic [WIDTH:0]     w_diff;
    logic               w_last_step;

    assign w_tgt_clamp  = (bus.cmd_target > MAX_V) ? MAX_V : bus.cmd_target;
    assign w_step_eff   = (bus.cmd_step == '0) ? WIDTH'(1) : bus.cmd_step;
    assign w_accept     = bus.cmd_valid && (r_state == ST_IDLE);
    assign w_jump       = (bus.cmd_div == '0) || (w_tgt_clamp == r_duty);
    assign w_sync_rise  = bus.sync_in && !r_sync_q;
    assign w_period_end = w_sync_rise && (r_pcnt == (r_div - DIV_W'(1)));

    // Distance is taken one bit wider so a full-scale swing never wraps.
    assign w_up        = r_tgt > r_duty;
    assign w_diff      = w_up ? ({1'b0, r_tgt} - {1'b0, r_duty})
                              : ({1'b0, r_duty} - {1'b0, r_tgt});
    assign w_last_step = w_diff <= {1'b0, r_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_tgt    <= '0;
            r_step   <= '0;
            r_div    <= '0;
            r_pcnt   <= '0;
            r_done   <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_tgt    <= w_tgt_nxt;
            r_step   <= w_step_nxt;
            r_div    <= w_div_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_done   <= w_done_nxt;
            r_sync_q <= bus.sync_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_jump) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_period_end && w_last_step) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_duty_nxt = r_duty;
        w_tgt_nxt  = r_tgt;
        w_step_nxt = r_step;
        w_div_nxt  = r_div;
        w_pcnt_nxt = r_pcnt;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tgt_nxt  = w_tgt_clamp;
                    w_step_nxt = w_step_eff;
                    w_div_nxt  = bus.cmd_div;
                    w_pcnt_nxt = '0;
                    if (w_jump) begin
                        w_duty_nxt = w_tgt_clamp;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RAMP: begin
                // Abort wins over a step landing on the same edge.
                if (bus.abort) begin
                    w_pcnt_nxt = '0;
                end else if (w_period_end) begin
                    w_pcnt_nxt = '0;
                    if (w_last_step) begin
                        w_duty_nxt = r_tgt;
                        w_done_nxt = 1'b1;
                    end else if (w_up) begin
                        w_duty_nxt = r_duty + r_step;
                    end else begin
                        w_duty_nxt = r_duty - r_step;
                    end
                end else if (w_sync_rise) begin
                    w_pcnt_nxt = r_pcnt + DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.duty_out  = r_duty;
    assign bus.done      = r_done;
    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_RAMP);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a vector table on an 8-bit/255 instance plus
// hand sequences for reset mid-ramp and a 7-bit/100 instance with a held sync.
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_ramp_if #(.WIDTH(8), .DIV_W(8)) a_if ();
  pwm_ramp_if #(.WIDTH(7), .DIV_W(8)) b_if ();
  logic a_dbg;
  logic b_dbg;

  pwm_ramp_ctrl #(.WIDTH(8), .MAX_VAL(255), .DIV_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave), .o_dbg_state(a_dbg)
  );
  pwm_ramp_ctrl #(.WIDTH(7), .MAX_VAL(100), .DIV_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave), .o_dbg_state(b_dbg)
  );

  typedef struct {
    logic       sync;
    logic       valid;
    logic [7:0] target;
    logic [7:0] step;
    logic [7:0] div;
    logic       abort;
    logic [7:0] duty;
    logic       ready;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic v, input int t, input int st, input int d,
                     input logic ab, input int du, input logic rd, input logic bz, input logic dn);
    vec_t e;
    e.sync = s; e.valid = v; e.target = 8'(t); e.step = 8'(st); e.div = 8'(d);
    e.abort = ab; e.duty = 8'(du); e.ready = rd; e.busy = bz; e.done = dn;
    vecs.push_back(e);
  endtask

  task automatic check_a(input int idx, input int duty, input logic rd, input logic bz, input logic dn);
    check("a_duty",  idx, 32'(a_if.duty_out), 32'(duty));
    check("a_ready", idx, 32'(a_if.cmd_ready), 32'(rd));
    check("a_busy",  idx, 32'(a_if.busy), 32'(bz));
    check("a_done",  idx, 32'(a_if.done), 32'(dn));
    check("a_state", idx, 32'(a_dbg), 32'(bz));
  endtask

  task automatic check_b(input int idx, input int duty, input logic rd, input logic bz, input logic dn);
    check("b_duty",  idx, 32'(b_if.duty_out), 32'(duty));
    check("b_ready", idx, 32'(b_if.cmd_ready), 32'(rd));
    check("b_busy",  idx, 32'(b_if.busy), 32'(bz));
    check("b_done",  idx, 32'(b_if.done), 32'(dn));
  endtask

  task automatic drive_a(input logic s, input logic v, input int t, input int st, input int d, input logic ab);
    a_if.sync_in = s; a_if.cmd_valid = v; a_if.cmd_target = 8'(t);
    a_if.cmd_step = 8'(st); a_if.cmd_div = 8'(d); a_if.abort = ab;
  endtask

  task automatic drive_b(input logic s, input logic v, input int t, input int st, input int d);
    b_if.sync_in = s; b_if.cmd_valid = v; b_if.cmd_target = 7'(t);
    b_if.cmd_step = 7'(st); b_if.cmd_div = 8'(d); b_if.abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);

    // Idle: sync pulses change nothing
    add(1,0,0,0,0,0,   0,1,0,0);
    add(0,0,0,0,0,0,   0,1,0,0);
    add(1,0,0,0,0,0,   0,1,0,0);
    add(0,0,0,0,0,0,   0,1,0,0);
    // Upward ramp 0 -> 200, step 50, div 1
    add(0,1,200,50,1,0, 0,0,1,0);
    for (int k = 1; k <= 4; k++) begin
      add(1,0,0,0,0,0, 50*k, k==4, k!=4, k==4);
      add(0,0,0,0,0,0, 50*k, k==4, k!=4, 0);
    end
    // Downward ramp 200 -> 30, step 64, div 2 (busy command mid-ramp is ignored)
    add(0,1,30,64,2,0, 200,0,1,0);
    add(1,0,0,0,0,0,   200,0,1,0);
    add(0,0,0,0,0,0,   200,0,1,0);
    add(1,0,0,0,0,0,   136,0,1,0);
    add(0,0,0,0,0,0,   136,0,1,0);
    add(0,1,5,1,0,0,   136,0,1,0);
    add(1,0,0,0,0,0,   136,0,1,0);
    add(0,0,0,0,0,0,   136,0,1,0);
    add(1,0,0,0,0,0,    72,0,1,0);
    add(0,0,0,0,0,0,    72,0,1,0);
    add(1,0,0,0,0,0,    72,0,1,0);
    add(0,0,0,0,0,0,    72,0,1,0);
    add(1,0,0,0,0,0,    30,1,0,1);
    add(0,0,0,0,0,0,    30,1,0,0);
    // Jump, div 0, with sync high on the same edge
    add(1,1,77,0,0,0,   77,1,0,1);
    add(0,0,0,0,0,0,    77,1,0,0);
    // Back to 0, ramp up, abort coincident with the step after 100
    add(0,1,0,0,0,0,     0,1,0,1);
    add(0,0,0,0,0,0,     0,1,0,0);
    add(0,1,200,50,1,0,  0,0,1,0);
    add(1,0,0,0,0,0,    50,0,1,0);
    add(0,0,0,0,0,0,    50,0,1,0);
    add(1,0,0,0,0,0,   100,0,1,0);
    add(0,0,0,0,0,0,   100,0,1,0);
    add(1,0,0,0,0,1,   100,1,0,0);
    add(0,0,0,0,0,0,   100,1,0,0);
    add(0,0,0,0,0,1,   100,1,0,0);
    add(0,1,150,50,1,0, 100,0,1,0);
    add(1,0,0,0,0,0,   150,1,0,1);
    add(0,0,0,0,0,0,   150,1,0,0);
    // Target equal to current duty completes at once even with div != 0
    add(0,1,150,10,3,0, 150,1,0,1);
    add(0,0,0,0,0,0,   150,1,0,0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_a(-1, 0, 1, 0, 0);
    check_b(-1, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].sync, vecs[i].valid, int'(vecs[i].target), int'(vecs[i].step),
              int'(vecs[i].div), vecs[i].abort);
      tick();
      check_a(i, int'(vecs[i].duty), vecs[i].ready, vecs[i].busy, vecs[i].done);
    end

    // Reset in the middle of a ramp discards it
    drive_a(0, 1, 10, 20, 1, 0);
    tick();
    check_a(1000, 150, 0, 1, 0);
    drive_a(1, 0, 0, 0, 0, 0);
    tick();
    check_a(1001, 130, 0, 1, 0);
    drive_a(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a(1002, 0, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 0);
    tick();
    check_a(1003, 0, 1, 0, 0);
    drive_a(0, 0, 0, 0, 0, 0);

    // 7-bit instance: target clamps to 100, step 0 acts as 1, held sync counts once
    drive_b(0, 1, 120, 0, 1);
    tick();
    check_b(2000, 0, 0, 1, 0);
    drive_b(1, 0, 0, 0, 0);
    tick();
    check_b(2001, 1, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_b(2002 + c, 1, 0, 1, 0);
    end
    drive_b(0, 0, 0, 0, 0);
    tick();
    for (int k = 2; k <= 100; k++) begin
      drive_b(1, 0, 0, 0, 0);
      tick();
      check_b(2100 + k, k, k == 100, k != 100, k == 100);
      drive_b(0, 0, 0, 0, 0);
      tick();
      check_b(2300 + k, k, k == 100, k != 100, 0);
    end
    drive_b(1, 0, 0, 0, 0);
    tick();
    check_b(2500, 100, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
